// File: rtl/dm_pkg.sv
// dm_pkg -- shared definitions for the dm_responder data-memory slice.
//
// Contents:
//   dm_state_e      : responder FSM state encoding (IDLE / WAIT / RESP)
//   BE_* constants  : byte-enable patterns that are legal for a 32-bit word
//   LATENCY_MIN/MAX : legal bounds of the dm_responder LATENCY parameter
//   CNT_W           : width of the latency down-counter (covers LATENCY_MAX-2)
//   be_legal()      : byte-enable / address-offset legality check
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  localparam int CNT_W       = 3;

  // Naturally aligned word, halfword and byte accesses are the only legal
  // shapes; a single-byte enable must sit on the lane named by the offset.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (be == BE_WORD && off == 2'd0) begin
      ok = 1'b1;
    end else if (be == BE_HALF_LO && off == 2'd0) begin
      ok = 1'b1;
    end else if (be == BE_HALF_HI && off == 2'd2) begin
      ok = 1'b1;
    end else if (be == (BE_BYTE0 << off)) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dm_be_merge.sv
// dm_be_merge -- combinational byte-enable legality check and lane merge.
//
// Ports:
//   be       [3:0]  byte-lane enables of the request
//   addr_lo  [1:0]  low address bits (byte offset inside the word)
//   old_word [31:0] current contents of the addressed storage word
//   wdata    [31:0] lane-positioned write data
//   legal           1 when the be/offset combination is an allowed access
//   merged   [31:0] old_word with every enabled lane replaced by wdata
module dm_be_merge
  import dm_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [31:0] merged
);

  assign legal = be_legal(be, addr_lo);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder -- single-outstanding data-memory responder with a fixed
// request-to-response latency and byte-lane write merging.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit storage words
//   LATENCY     : cycles from request acceptance to rsp_valid (1..8)
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid / req_ready : request handshake (ready only while idle)
//   req_we, req_be        : write flag and byte-lane enables
//   req_addr, req_wdata   : byte address and lane-positioned write data
//   req_pc                : issuing PC, only used by the write log
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : resulting word (0 on error) and error flag
//
// Configuration:
//   DM_WRITE_LOG_EN : when defined, each performed write prints one line
//                     "<time>@<pc>: *<word addr> <= <merged word>".
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT_EFF >= 2) ? LAT_EFF - 2 : 0);

  dm_state_e state, state_next;
  logic [CNT_W-1:0] cnt;

  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_pc;
  logic        in_range;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0] old_word;
  logic [31:0] merged_word;
  logic        be_ok;
  logic        op_ok;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 RESP is entered on the accepting edge itself, before the
  // latches hold the request, so the live inputs are used while idle.
  assign cur_we    = (state == ST_IDLE) ? req_we    : lat_we;
  assign cur_be    = (state == ST_IDLE) ? req_be    : lat_be;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign cur_pc    = (state == ST_IDLE) ? req_pc    : lat_pc;

  assign in_range = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));
  assign mem_idx  = cur_addr[IDX_W+1:2];
  assign old_word = in_range ? mem[mem_idx] : 32'h0;
  assign op_ok    = be_ok && in_range;

  dm_be_merge u_merge (
    .be       (cur_be),
    .addr_lo  (cur_addr[1:0]),
    .old_word (old_word),
    .wdata    (cur_wdata),
    .legal    (be_ok),
    .merged   (merged_word)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (LAT_EFF == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);

  // Request latches and latency down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_pc    <= '0;
    end else begin
      if (accept) begin
        cnt       <= CNT_LOAD;
        lat_we    <= req_we;
        lat_be    <= req_be;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_pc    <= req_pc;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Storage: the write lands only when the request reaches RESP, so a reset
  // during WAIT discards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (enter_resp && op_ok && cur_we) begin
      mem[mem_idx] <= merged_word;
    end
  end

  // Response word is captured once at RESP entry and held until handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= !op_ok;
      rsp_rdata <= !op_ok ? 32'h0 : (cur_we ? merged_word : old_word);
    end
  end

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (!reset && enter_resp && op_ok && cur_we) begin
      $display("%0t@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, merged_word);
    end
  end
`else
  // The PC only feeds the write log.
  logic log_unused;
  assign log_unused = ^cur_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder -- self-checking bench for dm_responder: directed
// scenarios followed by randomized traffic compared against a word-array
// reference model.
module tb_dm_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] model_mem [DEPTH];

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit model_legal(input logic [3:0] be, input logic [1:0] off);
    case (be)
      4'b1111: return off == 2'd0;
      4'b0011: return off == 2'd0;
      4'b1100: return off == 2'd2;
      4'b0001: return off == 2'd0;
      4'b0010: return off == 2'd1;
      4'b0100: return off == 2'd2;
      4'b1000: return off == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: compute expected response and update the model array.
  task automatic model_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp_data,
                              output logic exp_err);
    int unsigned idx;
    logic [31:0] word;
    idx = addr / 4;
    if (!model_legal(be, addr[1:0]) || idx >= DEPTH) begin
      exp_err  = 1'b1;
      exp_data = 32'h0;
    end else begin
      word = model_mem[idx];
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        model_mem[idx] = word;
      end
      exp_err  = 1'b0;
      exp_data = word;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // One full transaction: request, latency measurement, optional response
  // stall with a competing request, handshake and return to idle.
  task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, input int stall,
                               output logic [31:0] got_data, output logic got_err);
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] held;
    int          cyc;
    model_access(we, be, addr, wdata, exp_data, exp_err);
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = $urandom;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(LAT));
    checkOutput("rsp_rdata", rsp_rdata, exp_data);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    got_data = rsp_rdata;
    got_err  = rsp_err;
    held = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_be    = 4'b1111;
      req_addr  = 32'h4;
      req_wdata = $urandom;
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_rdata", rsp_rdata, held);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [3:0]  be;
    logic [1:0]  off;
    logic [31:0] addr;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 4'h0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_pc    = 32'h0;
    rsp_ready = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 4'b1111, 32'h10, 32'h12345678, 0, d, e);
    applyStimulus(1'b0, 4'b1111, 32'h10, 32'h0, 0, d, e);
    checkOutput("read_back_10", d, 32'h12345678);
    applyStimulus(1'b1, 4'b0010, 32'h11, 32'h0000AB00, 0, d, e);
    checkOutput("byte_merge", d, 32'h1234AB78);
    checkOutput("byte_merge_err", 32'(e), 32'd0);
    applyStimulus(1'b1, 4'b1111, 32'h12, 32'hDEADBEEF, 0, d, e);
    checkOutput("misaligned_err", 32'(e), 32'd1);
    checkOutput("misaligned_rdata", d, 32'h0);
    applyStimulus(1'b0, 4'b1111, 32'h10, 32'h0, 5, d, e);
    checkOutput("unchanged_10", d, 32'h1234AB78);
    // The stalled competing write to 0x4 must not have been performed.
    applyStimulus(1'b0, 4'b1111, 32'h4, 32'h0, 0, d, e);
    checkOutput("no_queued_write", d, 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h10, 32'h0, 0, d, e);
    checkOutput("be_zero_err", 32'(e), 32'd1);
    applyStimulus(1'b0, 4'b1111, 32'(4 * DEPTH), 32'h0, 0, d, e);
    checkOutput("oob_err", 32'(e), 32'd1);
    applyStimulus(1'b1, 4'b1111, 32'(4 * DEPTH - 4), 32'hCAFEF00D, 0, d, e);
    checkOutput("last_word_ok", 32'(e), 32'd0);

    // Reset while a write to 0x20 is in WAIT.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'b1111;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("mid_reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_reset_ready", 32'(req_ready), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 4'b1111, 32'h20, 32'h0, 0, d, e);
    checkOutput("dropped_write_20", d, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: begin be = 4'b1111; off = 2'd0; end
          1: begin be = 4'b0011; off = 2'd0; end
          2: begin be = 4'b1100; off = 2'd2; end
          default: begin off = 2'($urandom_range(0, 3)); be = 4'b0001 << off; end
        endcase
      end else begin
        be  = 4'($urandom);
        off = 2'($urandom);
      end
      addr = {$urandom_range(0, DEPTH + 2), off};
      applyStimulus(1'($urandom), be, addr, $urandom, $urandom_range(0, 3), d, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 3072: number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal 1..8: cycles from request acceptance to rsp_valid rising.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: reset is asynchronous and active-high.
REQ-005 Port req_valid SHALL be input, 1 bit: initiator presents a request.
REQ-006 Port req_ready SHALL be output, 1 bit: responder can accept a request.
REQ-007 Port req_we SHALL be input, 1 bit: 1 = write, 0 = read.
REQ-008 Port req_be SHALL be input, 4 bits: byte-lane enables, bit i = byte lane i (bits 8i+7:8i).
REQ-009 Port req_addr SHALL be input, 32 bits: byte address.
REQ-010 Port req_wdata SHALL be input, 32 bits: write data, already lane-positioned.
REQ-011 Port req_pc SHALL be input, 32 bits: PC of the issuing instruction, used only for the write log.
REQ-012 Port rsp_valid SHALL be output, 1 bit: response present.
REQ-013 Port rsp_ready SHALL be input, 1 bit: initiator accepts the response.
REQ-014 Port rsp_rdata SHALL be output, 32 bits: full word read (post-write word for writes).
REQ-015 Port rsp_err SHALL be output, 1 bit: request was illegal and was not performed.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL equal (state==IDLE).
REQ-017 A request SHALL be accepted on a rising edge with req_valid && req_ready; req_we, req_be, req_addr, req_wdata and req_pc SHALL be latched at that edge.
REQ-018 On accept, the FSM SHALL go to RESP if LATENCY==1; otherwise it SHALL go to WAIT with a counter loaded to LATENCY-2.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-020 On entry to RESP: word index = latched addr[31:2]; an accepted write SHALL update only the enabled lanes; rsp_rdata SHALL be the resulting word.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid && rsp_ready.
REQ-022 On the response handshake, the FSM SHALL go to IDLE and rsp_valid SHALL drop; a new request SHALL be accepted no earlier than the following edge.
REQ-023 The only legal req_be patterns SHALL be: 1111 with addr[1:0]=0; 0011 with addr[1:0]=0; 1100 with addr[1:0]=2; a single bit i with addr[1:0]=i.
REQ-024 Any other req_be pattern (including 0000), or index >= DEPTH_WORDS, SHALL give rsp_err=1 and rsp_rdata=0, with no storage change.
REQ-025 req_valid SHALL be ignored while state != IDLE; the responder SHALL NOT queue requests.

Reset
REQ-026 While reset is high: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, every storage word=0.
REQ-027 Reset asserted in WAIT or RESP SHALL drop the transaction; a write that has not reached RESP SHALL NOT be performed.

Configuration
REQ-028 With DM_WRITE_LOG_EN defined, each performed write SHALL print one line "<time>@<req_pc hex>: *<word-aligned byte addr hex> <= <merged word hex>" at RESP entry.
REQ-029 Errored writes SHALL NOT be logged.
REQ-030 With DM_WRITE_LOG_EN undefined, nothing SHALL be printed; all other behaviour SHALL be identical.

Structure
REQ-031 A shared package dm_pkg SHALL hold the FSM state encoding, legal byte-enable constants and the LATENCY bounds.
REQ-032 Sub-module dm_be_merge (combinational) SHALL perform the legality check and the lane merge of old word with wdata.

Verification
REQ-033 Reset, then a write of 0x12345678 to addr 0x10 with be=1111 and LATENCY=2, then a read of 0x10 SHALL return rsp_rdata=0x12345678 exactly 2 cycles after each acceptance.
REQ-034 After REQ-033, a write of 0x0000AB00 with be=0010 to addr 0x11 SHALL return rsp_rdata=0x1234AB78, rsp_err=0.
REQ-035 A write with be=1111 to addr 0x12 SHALL return rsp_err=1 and rsp_rdata=0; a following read of 0x10 SHALL return the unchanged word.
REQ-036 Holding rsp_ready=0 for 5 cycles SHALL hold rsp_valid=1 with stable data; a second req_valid during this time SHALL see req_ready=0 and SHALL NOT be accepted.
REQ-037 Reset asserted in WAIT of a write to addr 0x20 SHALL leave word 0x20 at 0 and give rsp_valid=0 immediately.
REQ-038 A read of byte address 4*DEPTH_WORDS SHALL return rsp_err=1; with DM_WRITE_LOG_EN, a legal write SHALL produce exactly one log line.
